stage_timing_io: RTL and testbench

Pipeline support block for the four-stage processor chipset. It generates the free-running stage sequence (stage index plus one-hot per-stage strobes), selects the active stage's 16-bit RAM address, and provides the read port for the input-device bus. It sits between the core clock and the STAGE0–STAGE3 datapath, RAM and input devices.

---
 rtl/chipset_pkg.sv | 27 ++
 rtl/stage_timing_io_if.sv | 30 +++
 rtl/stage_timing_io_idev_sync.sv | 31 +++
 rtl/stage_timing_io.sv | 95 +++++++++
 tb/tb_stage_timing_io.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/chipset_pkg.sv
// Shared definitions for the four-stage processor chipset support logic.
// Holds the bus widths, the stage index constants, the input-device
// addresses and the stage-to-strobe decode used by stage_timing_io.
package chipset_pkg;

  localparam int STAGE_W     = 2;
  localparam int ADDR_W      = 16;
  localparam int WORD_W      = 32;
  localparam int IDEV_ADDR_W = 8;

  localparam logic [STAGE_W-1:0] STAGE0 = 2'd0;
  localparam logic [STAGE_W-1:0] STAGE1 = 2'd1;
  localparam logic [STAGE_W-1:0] STAGE2 = 2'd2;
  localparam logic [STAGE_W-1:0] STAGE3 = 2'd3;

  localparam logic [IDEV_ADDR_W-1:0] IDEV0_ADDR = 8'h00;
  localparam logic [IDEV_ADDR_W-1:0] IDEV1_ADDR = 8'h01;

  // One-hot strobe for a stage index. The strobe vector is ascending
  // ([0:3]), so the leftmost literal bit is stage 0.
  function automatic logic [0:3] phase_decode(input logic [STAGE_W-1:0] stage);
    logic [0:3] ph;
    ph = 4'b1000 >> stage;
    return ph;
  endfunction

endpackage

// File: rtl/stage_timing_io_if.sv
// Bus bundle between the stage datapath and stage_timing_io.
//   A0..A3       : RAM address proposed by each stage
//   S            : address-mux select (normally the current stage index)
//   value        : selected RAM address
//   idev_address : input-device address from STAGE1
//   idev_value   : read data for idev_address
// master = datapath side (drives addresses/selects), slave = this block.
interface stage_timing_io_if;
  import chipset_pkg::*;

  logic [ADDR_W-1:0]      A0;
  logic [ADDR_W-1:0]      A1;
  logic [ADDR_W-1:0]      A2;
  logic [ADDR_W-1:0]      A3;
  logic [STAGE_W-1:0]     S;
  logic [ADDR_W-1:0]      value;
  logic [IDEV_ADDR_W-1:0] idev_address;
  logic [WORD_W-1:0]      idev_value;

  modport master (
    output A0, A1, A2, A3, S, idev_address,
    input  value, idev_value
  );

  modport slave (
    input  A0, A1, A2, A3, S, idev_address,
    output value, idev_value
  );

endinterface

// File: rtl/stage_timing_io_idev_sync.sv
// idev_sync: two-flop synchronizer for one input device word.
//   clk     : system clock
//   reset_n : synchronous active-low reset, clears both flop stages
//   d_i     : raw (asynchronous) device value
//   q_o     : synchronized value, two rising edges behind d_i
module idev_sync
  import chipset_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] d_i,
  output logic [WORD_W-1:0] q_o
);

  logic [WORD_W-1:0] meta_p0_q;
  logic [WORD_W-1:0] sync_p1_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_p0_q <= '0;
      sync_p1_q <= '0;
    end else begin
      // first flop may go metastable; second flop gives it a cycle to settle
      meta_p0_q <= d_i;
      sync_p1_q <= meta_p0_q;
    end
  end

  assign q_o = sync_p1_q;

endmodule

// File: rtl/stage_timing_io.sv
// stage_timing_io: pipeline support block for the four-stage chipset.
// Generates the free-running stage index and one-hot stage strobes,
// multiplexes the active stage's RAM address, and serves reads of the
// synchronized input-device values.
//   clk            : system clock, all state on the rising edge
//   reset_n        : synchronous active-low reset
//   bus            : slave side of stage_timing_io_if (A0..A3, S, value,
//                    idev_address, idev_value)
//   device0_values : raw value of input device 0
//   device1_values : raw value of input device 1
//   clk_phase      : one-hot stage strobe, clk_phase[i] high in stage i
//   clk_stage      : current stage index 0..3
module stage_timing_io
  import chipset_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int NUM_IDEV   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  stage_timing_io_if.slave   bus,
  input  logic [WORD_W-1:0]  device0_values,
  input  logic [WORD_W-1:0]  device1_values,
  output logic [0:3]         clk_phase,
  output logic [STAGE_W-1:0] clk_stage
);

  logic [STAGE_W-1:0] stage_q;
  logic [STAGE_W-1:0] stage_d;
  logic [0:3]         phase_q;
  logic [0:3]         phase_d;

  logic [WORD_W-1:0]  dev_raw  [NUM_IDEV];
  logic [WORD_W-1:0]  dev_sync [NUM_IDEV];

  // Stage counter: free-running, wraps after the last stage.
  always_comb begin
    if (stage_q == STAGE_W'(NUM_STAGES - 1)) begin
      stage_d = STAGE0;
    end else begin
      stage_d = stage_q + STAGE_W'(1);
    end
    // decoded from the next index so the registered strobe lines up
    // with the registered index
    phase_d = phase_decode(stage_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q <= STAGE0;
      phase_q <= phase_decode(STAGE0);
    end else begin
      stage_q <= stage_d;
      phase_q <= phase_d;
    end
  end

  assign clk_stage = stage_q;
  assign clk_phase = phase_q;

  // Address mux: zero latency, every select code is meaningful.
  always_comb begin
    bus.value = bus.A0;
    case (bus.S)
      STAGE0:  bus.value = bus.A0;
      STAGE1:  bus.value = bus.A1;
      STAGE2:  bus.value = bus.A2;
      STAGE3:  bus.value = bus.A3;
      default: bus.value = bus.A0;
    endcase
  end

  // Input devices: synchronize each raw word, then decode combinationally.
  assign dev_raw[0] = device0_values;
  assign dev_raw[1] = device1_values;

  for (genvar g = 0; g < NUM_IDEV; g++) begin : g_idev
    idev_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (dev_raw[g]),
      .q_o     (dev_sync[g])
    );
  end

  always_comb begin
    bus.idev_value = '0;
    case (bus.idev_address)
      IDEV0_ADDR: bus.idev_value = dev_sync[0];
      IDEV1_ADDR: bus.idev_value = dev_sync[1];
      default:    bus.idev_value = '0;
    endcase
  end

endmodule

// File: tb/tb_stage_timing_io.sv
module tb_stage_timing_io;
  import chipset_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic [WORD_W-1:0] device0_values;
  logic [WORD_W-1:0] device1_values;
  logic [0:3]        clk_phase;
  logic [1:0]        clk_stage;

  stage_timing_io_if bus ();

  stage_timing_io #(.NUM_STAGES(4), .NUM_IDEV(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus.slave),
    .device0_values (device0_values),
    .device1_values (device1_values),
    .clk_phase      (clk_phase),
    .clk_stage      (clk_stage)
  );

  exp_t        sb[$];
  int          n_cmp;
  int          n_bad;
  logic [15:0] a_tab [4];
  logic [1:0]  exp_stage;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic check_stage(input logic [1:0] st, input logic [0:3] ph);
    expect_val("clk_stage", {30'd0, st});
    expect_val("clk_phase", {28'd0, ph});
    check({30'd0, clk_stage});
    check({28'd0, clk_phase});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    a_tab[0] = 16'h0001;
    a_tab[1] = 16'h0010;
    a_tab[2] = 16'h0100;
    a_tab[3] = 16'h1000;

    reset_n          = 1'b0;
    device0_values   = '0;
    device1_values   = 32'h3;
    bus.A0           = '0;
    bus.A1           = '0;
    bus.A2           = '0;
    bus.A3           = '0;
    bus.S            = 2'd0;
    bus.idev_address = 8'h01;

    // reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      check_stage(2'd0, 4'b1000);
    end
    expect_val("idev_in_reset", 32'h0);
    check(bus.idev_value);

    // release and run the rotation
    reset_n = 1'b1;
    tick(); check_stage(2'd1, 4'b0100);
    tick(); check_stage(2'd2, 4'b0010);
    tick(); check_stage(2'd3, 4'b0001);
    tick(); check_stage(2'd0, 4'b1000);
    tick(); check_stage(2'd1, 4'b0100);
    tick(); check_stage(2'd2, 4'b0010);

    // mid-sequence reset while in stage 2
    reset_n = 1'b0;
    tick(); check_stage(2'd0, 4'b1000);
    reset_n = 1'b1;
    exp_stage = 2'd0;

    // address mux sweep, same-cycle response
    bus.A0 = a_tab[0];
    bus.A1 = a_tab[1];
    bus.A2 = a_tab[2];
    bus.A3 = a_tab[3];
    for (int s = 0; s < 4; s++) begin
      bus.S = 2'(s);
      expect_val("mux_sweep", {16'd0, a_tab[s]});
      #1;
      check({16'd0, bus.value});
    end

    // select tied to the stage rotation
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_stage = exp_stage + 2'd1;
      bus.S = clk_stage;
      expect_val("mux_rotate_stage", {30'd0, exp_stage});
      expect_val("mux_rotate", {16'd0, a_tab[exp_stage]});
      #1;
      check({30'd0, clk_stage});
      check({16'd0, bus.value});
    end

    // device decode with settled inputs
    device0_values = 32'h2;
    device1_values = 32'h3;
    tick();
    tick();
    bus.idev_address = 8'd0;   expect_val("idev_addr0", 32'h2);   #1; check(bus.idev_value);
    bus.idev_address = 8'd1;   expect_val("idev_addr1", 32'h3);   #1; check(bus.idev_value);
    bus.idev_address = 8'd2;   expect_val("idev_addr2", 32'h0);   #1; check(bus.idev_value);
    bus.idev_address = 8'd255; expect_val("idev_addr255", 32'h0); #1; check(bus.idev_value);

    // synchronizer latency on device 0
    bus.idev_address = 8'd0;
    device0_values   = 32'hDEAD_BEEF;
    expect_val("sync_edge1", 32'h2);
    expect_val("sync_edge2", 32'hDEAD_BEEF);
    tick(); check(bus.idev_value);
    tick(); check(bus.idev_value);

    // address change selects already-synchronized data at once
    bus.idev_address = 8'd1;
    device1_values   = 32'h7;
    expect_val("addr_switch_old_data", 32'h3);
    #1; check(bus.idev_value);
    device1_values = 32'h3;
    tick();
    tick();

    // reset clears the synchronizers
    reset_n = 1'b0;
    tick();
    expect_val("idev_reset_clear", 32'h0);
    check(bus.idev_value);
    reset_n = 1'b1;
    expect_val("idev_after_rel1", 32'h0);
    expect_val("idev_after_rel2", 32'h3);
    tick(); check(bus.idev_value);
    tick(); check(bus.idev_value);

    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
